// File: rtl/gcd_ctrl.sv
// Sequencer for the subtractive GCD engine: accepts operand pairs, loads and runs
// the engine, bypasses zero operands, abandons runaway jobs and returns results.
module gcd_ctrl #(
    parameter int unsigned WIDTH   = 40,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_coprime,
    output logic             out_zero,
    output logic             out_timeout,
    output logic [CNT_W-1:0] out_cycles,
    output logic             eng_reset,
    output logic [WIDTH-1:0] eng_x,
    output logic [WIDTH-1:0] eng_y,
    input  logic [WIDTH-1:0] eng_result
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_gcd_q;
    logic             out_coprime_q;
    logic             out_zero_q;
    logic             out_timeout_q;
    logic [CNT_W-1:0] out_cycles_q;
    logic             eng_reset_q;
    logic [WIDTH-1:0] eng_x_q;
    logic [WIDTH-1:0] eng_y_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] bypass_gcd_d;

    // Saturating increment of the RUN-cycle counter.
    always_comb begin
        cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        bypass_gcd_d = in_x | in_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_gcd_q     <= '0;
            out_coprime_q <= 1'b0;
            out_zero_q    <= 1'b0;
            out_timeout_q <= 1'b0;
            out_cycles_q  <= '0;
            eng_reset_q   <= 1'b1;
            eng_x_q       <= '0;
            eng_y_q       <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_ready_q && in_valid) begin
                        eng_x_q    <= in_x;
                        eng_y_q    <= in_y;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (in_x == '0 || in_y == '0) begin
                            state_q       <= DONE;
                            out_valid_q   <= 1'b1;
                            out_zero_q    <= 1'b1;
                            out_cycles_q  <= '0;
                            out_gcd_q     <= bypass_gcd_d;
                            out_coprime_q <= (bypass_gcd_d == WIDTH'(1));
                        end else begin
                            state_q <= LOAD;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q     <= RUN;
                    eng_reset_q <= 1'b0;
                end
                RUN: begin
                    if (eng_result != '0) begin
                        state_q       <= DONE;
                        eng_reset_q   <= 1'b1;
                        out_valid_q   <= 1'b1;
                        out_gcd_q     <= eng_result;
                        out_coprime_q <= (eng_result == WIDTH'(1));
                        out_cycles_q  <= cnt_q;
                    end else if (cnt_q == TO_LAST) begin
                        // The final busy cycle is counted, so a timeout reports TIMEOUT cycles.
                        state_q       <= DONE;
                        eng_reset_q   <= 1'b1;
                        out_valid_q   <= 1'b1;
                        out_gcd_q     <= '0;
                        out_coprime_q <= 1'b0;
                        out_timeout_q <= 1'b1;
                        out_cycles_q  <= cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q       <= IDLE;
                        in_ready_q    <= 1'b1;
                        out_valid_q   <= 1'b0;
                        out_coprime_q <= 1'b0;
                        out_zero_q    <= 1'b0;
                        out_timeout_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_gcd     = out_gcd_q;
    assign out_coprime = out_coprime_q;
    assign out_zero    = out_zero_q;
    assign out_timeout = out_timeout_q;
    assign out_cycles  = out_cycles_q;
    assign eng_reset   = eng_reset_q;
    assign eng_x       = eng_x_q;
    assign eng_y       = eng_y_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl: two instances (default TIMEOUT and TIMEOUT=4), each
// paired with a behavioural subtractive GCD engine with synchronous reset.
module tb_gcd_ctrl;

    localparam int W = 40;
    localparam int C = 24;

    logic         clk;
    logic         reset;
    logic         in_valid    [2];
    logic         in_ready    [2];
    logic [W-1:0] in_x        [2];
    logic [W-1:0] in_y        [2];
    logic         out_valid   [2];
    logic         out_ready   [2];
    logic [W-1:0] out_gcd     [2];
    logic         out_coprime [2];
    logic         out_zero    [2];
    logic         out_timeout [2];
    logic [C-1:0] out_cycles  [2];
    logic         eng_reset   [2];
    logic [W-1:0] eng_x       [2];
    logic [W-1:0] eng_y       [2];
    logic [W-1:0] eng_result  [2];
    logic [W-1:0] ea          [2];
    logic [W-1:0] eb          [2];

    int n_checks = 0;
    int n_errors = 0;

    gcd_ctrl #(.WIDTH(W), .CNT_W(C)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]), .in_y(in_y[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_gcd(out_gcd[0]),
        .out_coprime(out_coprime[0]), .out_zero(out_zero[0]), .out_timeout(out_timeout[0]),
        .out_cycles(out_cycles[0]), .eng_reset(eng_reset[0]), .eng_x(eng_x[0]),
        .eng_y(eng_y[0]), .eng_result(eng_result[0])
    );

    gcd_ctrl #(.WIDTH(W), .CNT_W(C), .TIMEOUT(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]), .in_y(in_y[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_gcd(out_gcd[1]),
        .out_coprime(out_coprime[1]), .out_zero(out_zero[1]), .out_timeout(out_timeout[1]),
        .out_cycles(out_cycles[1]), .eng_reset(eng_reset[1]), .eng_x(eng_x[1]),
        .eng_y(eng_y[1]), .eng_result(eng_result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine: loads on reset, subtracts while busy, registers the result once x==y.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (eng_reset[i]) begin
                ea[i]         <= eng_x[i];
                eb[i]         <= eng_y[i];
                eng_result[i] <= '0;
            end else if (ea[i] == eb[i]) begin
                eng_result[i] <= ea[i];
            end else if (ea[i] > eb[i]) begin
                ea[i] <= ea[i] - eb[i];
            end else begin
                eb[i] <= eb[i] - ea[i];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] gcd, input logic cop, input logic zr,
                           input logic to, input int cyc, input int lat, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready[d]), 64'd1);
        in_x[d]     = x;
        in_y[d]     = y;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", 64'(out_valid[d]), 64'd1);
        if (lat >= 0) check("latency", 64'(n), 64'(lat));
        check("out_gcd", 64'(out_gcd[d]), 64'(gcd));
        check("out_coprime", 64'(out_coprime[d]), 64'(cop));
        check("out_zero", 64'(out_zero[d]), 64'(zr));
        check("out_timeout", 64'(out_timeout[d]), 64'(to));
        check("out_cycles", 64'(out_cycles[d]), 64'(cyc));
        check("in_ready_busy", 64'(in_ready[d]), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid[d]), 64'd1);
            check("stall_gcd", 64'(out_gcd[d]), 64'(gcd));
            check("stall_cycles", 64'(out_cycles[d]), 64'(cyc));
            check("stall_in_ready", 64'(in_ready[d]), 64'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        @(negedge clk);
        check("valid_drop", 64'(out_valid[d]), 64'd0);
        check("flags_clear", 64'({out_zero[d], out_timeout[d], out_coprime[d]}), 64'd0);
        check("in_ready_back", 64'(in_ready[d]), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_x[i]      = '0;
            in_y[i]      = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready[0]), 64'd0);
        check("rst_eng_reset", 64'(eng_reset[0]), 64'd1);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_eng_x", 64'(eng_x[0]), 64'd0);
        check("rst_out_gcd", 64'(out_gcd[0]), 64'd0);
        reset = 1'b0;
        #1 check("rel_in_ready_low", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready[0]), 64'd1);

        //      d  x     y   gcd  cop zr to cyc lat stall
        run_job(0, 12,   8,  4,   0,  0, 0, 3,  6,  10);
        run_job(0, 7,    7,  7,   0,  0, 0, 1,  4,  0);
        run_job(0, 35,   64, 1,   1,  0, 0, 12, 15, 0);
        run_job(0, 0,    9,  9,   0,  1, 0, 0,  1,  0);
        run_job(0, 0,    0,  0,   0,  1, 0, 0,  1,  0);
        run_job(1, 1000, 1,  0,   0,  0, 1, 4,  -1, 0);
        run_job(1, 9,    6,  3,   0,  0, 0, 3,  6,  0);

        // Reset in the middle of a RUN phase
        @(negedge clk);
        in_x[0]     = 35;
        in_y[0]     = 64;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_eng_reset", 64'(eng_reset[0]), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
        check("mid_rst_eng_reset", 64'(eng_reset[0]), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
        run_job(0, 7, 7, 7, 0, 0, 0, 1, 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
